// File: rtl/seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider_pkg
// Shared ALU/datapath constants used by the sequential DIV execution unit.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seq_divider_pkg;

  // Operand width of the datapath
  localparam int DIV_WIDTH = 32;

  // ALU operation code that launches the divider
  localparam logic [3:0] ALU_OP_DIV = 4'b0110;

  // Edges from start-accept to the done pulse
  localparam int DIV_LATENCY = 33;

  // Divider control states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seq_divider_step.sv
// ----------------------------------------------------------------------------
// seq_divider_step
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor magnitude, and select the new quotient bit.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   dmag,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             qbit;

  // Shift, trial subtract, and keep the difference only when it did not borrow.
  // A kept difference is always below dmag (at most 2^(WIDTH-1)), so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {1'b0, dmag};
    qbit    = ~diff[WIDTH+1];
    rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], qbit};
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed divider for the DIV ALU op. Returns {remainder, quotient}
// after a fixed 33-edge latency using a start/busy/done handshake.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] z_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dmag;
  logic             neg_rem;
  logic             neg_quo;
  logic             dzero;
  logic [WIDTH-1:0] orig_dd;

  logic [WIDTH:0]   dd_ext;
  logic [WIDTH:0]   dv_ext;
  logic [WIDTH:0]   dd_abs;
  logic [WIDTH:0]   dv_abs;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes in WIDTH+1 bits so the most negative value is exact
  always_comb begin
    dd_ext = {dividend[WIDTH-1], dividend};
    dv_ext = {divisor[WIDTH-1], divisor};
    dd_abs = dd_ext[WIDTH] ? (~dd_ext + (WIDTH+1)'(1)) : dd_ext;
    dv_abs = dv_ext[WIDTH] ? (~dv_ext + (WIDTH+1)'(1)) : dv_ext;
  end

  seq_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dmag    (dmag),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Sign correction of the finished magnitudes; a zero divisor bypasses it
  always_comb begin
    if (dzero) begin
      q_fix = '1;
      r_fix = orig_dd;
    end else begin
      q_fix = neg_quo ? (~quo + WIDTH'(1)) : quo;
      r_fix = neg_rem ? (~rem + WIDTH'(1)) : rem;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dmag        <= '0;
      neg_rem     <= 1'b0;
      neg_quo     <= 1'b0;
      dzero       <= 1'b0;
      orig_dd     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      z_out       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            quo     <= dd_abs[WIDTH-1:0];
            dmag    <= dv_abs;
            rem     <= '0;
            count   <= '0;
            neg_rem <= dividend[WIDTH-1];
            neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dzero   <= (divisor == '0);
            orig_dd <= dividend;
            busy    <= 1'b1;
            state   <= ST_ITER;
          end
        end
        ST_ITER: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          z_out       <= {r_fix, q_fix};
          div_by_zero <= dzero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Randomised scoreboard bench for seq_divider against an arithmetic model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] z_out;

  typedef struct {
    logic [63:0] z;
    logic        dz;
    int unsigned cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        scb[$];
  int unsigned cyc;
  int          n_assert;
  int          n_fail;
  logic        prev_done;

  seq_divider dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_out       (z_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog: the run must never hang
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: signed division truncating toward zero, remainder follows dividend
  function automatic logic [63:0] ref_z(input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'(signed'(a));
    sd = longint'(signed'(b));
    q  = sa / sd;
    r  = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever the DUT signals completion
  always @(negedge clock) begin
    exp_t e;
    if (clear_n) begin
      if (done) begin
        n_assert++;
        if (busy || prev_done) begin
          n_fail++;
          $display("FAIL done_shape: busy=%b prev_done=%b expected busy=0 prev_done=0", busy, prev_done);
        end
        n_assert++;
        if (scb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected no completion", cyc);
        end else begin
          e = scb.pop_front();
          if (z_out !== e.z || div_by_zero !== e.dz || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL result %h/%h: got z=%h dz=%b cyc=%0d expected z=%h dz=%b cyc=%0d",
                     e.a, e.b, z_out, div_by_zero, cyc, e.z, e.dz, e.cyc);
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Issue one operation; busy-period inputs are garbage the DUT must ignore
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    e.z   = ref_z(a, b);
    e.dz  = (b == 32'd0);
    e.cyc = cyc + 33;
    e.a   = a;
    e.b   = b;
    scb.push_back(e);
    for (int i = 0; i < 33; i++) begin
      @(negedge clock);
      start    = hold ? 1'b1 : 1'($urandom % 2);
      dividend = $urandom;
      divisor  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    cyc       = 0;
    n_assert  = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    clear_n   = 1'b0;
    start     = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dz", 64'(div_by_zero), 64'd0);
    chk("reset_z", z_out, 64'd0);
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    idle(2);

    // Directed cases, chained back-to-back with start held high
    run_op(32'd6, 32'd4, 1'b0);
    idle(1);
    run_op(-32'sd7, 32'd2, 1'b1);
    run_op(32'd7, -32'sd2, 1'b1);
    run_op(-32'sd7, -32'sd2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(2);
    run_op(32'd5, 32'd0, 1'b0);
    idle(3);

    // Abort mid-operation: outputs drop at once and no done follows
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd6;
    divisor  = 32'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_dz", 64'(div_by_zero), 64'd0);
    chk("abort_z", z_out, 64'd0);
    idle(3);
    clear_n = 1'b1;
    idle(40);
    run_op(32'd6, 32'd4, 1'b0);
    idle(2);

    // Randomised operations with corner-biased operands and random spacing
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(40);

    chk("scoreboard_drained", 64'(scb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed 32-bit divider that serves as the DIV execution unit behind the ALU. The datapath starts it when ALU_op = DIV (4'b0110). It returns a 64-bit result to be loaded into Z: the quotient in Zlow, for transfer to LO, and the remainder in Zhigh, for transfer to HI. The control sequencer uses the start/busy/done handshake to hold in its T4 step until the result is ready.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clock  input  1  system clock; all state updates on the rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (Y register value); sampled on the accepting edge only.
- divisor  input  WIDTH  signed divisor (bus value); sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; z_out is valid from this cycle onward.
- div_by_zero  output  1  registered flag for the last completed operation.
- z_out  output  2*WIDTH  {remainder, quotient}; holds until the next completion.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, start=1:
  - latch the operand signs, |dividend| and |divisor|.
  - clear the partial remainder; iteration count = 0.
  - set the zero-divisor flag if divisor == 0.
  - go to ITER.
- IDLE, start=0: stay in IDLE.
- ITER, one restoring step per cycle:
  - shift {rem, quo} left 1.
  - trial-subtract |divisor| from rem.
  - if the result is non-negative, keep it and set quotient bit = 1.
  - after WIDTH steps, go to FIX.
- FIX:
  - apply sign correction and register z_out and div_by_zero.
  - pulse done; go to IDLE.
- Sign rules:
  - quotient truncates toward zero; it is negated if the operand signs differ.
  - remainder takes the sign of the dividend.
  - magnitudes are computed in WIDTH+1 bits so that |−2^31| is exact.
- Overflow: −2^31 / −1 gives quotient 0x80000000, remainder 0 (two's-complement wrap); no flag.
- Divide by zero:
  - sign correction is bypassed.
  - quotient = all ones; remainder = original dividend.
  - div_by_zero = 1; latency is unchanged.
- start while busy=1 or done=1 is ignored; no queuing.
- Operand changes after the accepting edge have no effect.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, z_out=0, state=IDLE, iteration count=0.
- start=1 sampled at edge E0:
  - busy rises after E0.
  - edges E1..E32 perform the iterations; FIX is entered after E32.
  - z_out, div_by_zero and done update at E33; busy falls after E33.
- Fixed latency: 33 edges, start-accept to done. Throughput: one operation per 34 cycles.
- In the done cycle the state is IDLE with busy=0. A start in that cycle is accepted at E34, allowing back-to-back operations with a 1-cycle gap.
- busy and done are never high together.
- done is high for exactly one cycle.
- clear_n low at any time, including mid-ITER:
  - all outputs and state return to their reset values immediately.
  - no done is produced for the aborted operation.
  - operation resumes from IDLE after clear_n rises.

## Structure
- Shared package (existing ALU/datapath package):
  - ALU op constant ALU_OP_DIV = 4'b0110.
  - divider state enum {IDLE, ITER, FIX}.
  - DIV_LATENCY = 33.
- Natural sub-module: div_step, a combinational single restoring iteration (shift, trial subtract, select quotient bit). It is instanced once and reused each cycle.
- No memories; all registers are flat.

## Test plan
- Basic: 6 / 4 → after 33 edges done=1, z_out = 0x00000002_00000001, div_by_zero=0.
- Signs:
  - −7 / 2 → z_out = 0xFFFFFFFF_FFFFFFFD.
  - 7 / −2 → z_out = 0x00000001_FFFFFFFD.
  - −7 / −2 → z_out = 0xFFFFFFFF_00000003.
- Overflow: 0x80000000 / 0xFFFFFFFF → z_out = 0x00000000_80000000, div_by_zero=0.
- Divide by zero: 5 / 0 → done at 33 edges, z_out = 0x00000005_FFFFFFFF, div_by_zero=1.
- Handshake:
  - start held high continuously → one operation per 34 cycles.
  - operand changes while busy have no effect.
  - a start pulse mid-operation is ignored.
- Reset mid-operation: clear_n low at iteration 10 → busy=0, z_out=0 immediately and no done. A new 6 / 4 after release completes normally.
